// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing and buffering: enable/soft-reset control with graceful drain,
// show-ahead RX FIFO, sticky error flags, idle character timeout and level interrupt.
module uart_rx_ctrl #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic                          cfg_enable,
    input  logic                          cfg_flush,
    input  logic [TIMEOUT_W-1:0]          cfg_timeout,
    input  logic                          err_clr,
    input  logic                          rd_pop,
    input  logic                          rx_done,
    input  logic                          rx_busy,
    input  logic                          rx_error,
    input  logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_en,
    output logic                          rx_rst,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovr_err,
    output logic                          frm_err,
    output logic                          timeout_flag,
    output logic                          irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StOff, StFlush, StActive, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   ovr_q, ovr_d, frm_q, frm_d, flag_q, flag_d;
    logic [TIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic capture, full, pop_acc, push, ovr_set, frm_set, tmo_clr;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= StOff;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            frm_q     <= 1'b0;
            flag_q    <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            frm_q     <= frm_d;
            flag_q    <= flag_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOff:    if (cfg_flush || cfg_enable) state_d = StFlush;
            StFlush:  state_d = cfg_enable ? StActive : StOff;
            StActive: begin
                if (cfg_flush)                          state_d = StFlush;
                else if (!cfg_enable && (rx_busy || rx_done)) state_d = StDrain;
                else if (!cfg_enable)                   state_d = StOff;
            end
            StDrain: begin
                if (cfg_flush)                 state_d = StFlush;
                else if (!rx_busy && !rx_done) state_d = StOff;
            end
            default:  state_d = StOff;
        endcase
    end

    always_comb begin
        rx_en  = (state_q == StActive);
        rx_rst = (state_q == StFlush);
    end

    // Writes are allowed into a full FIFO only when the head is popped in the same cycle.
    assign capture = rx_done && (state_q == StActive || state_q == StDrain);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop_acc = rd_pop && rd_valid;
    assign push    = capture && !rx_error && (!full || pop_acc);
    assign ovr_set = capture && !rx_error && full && !pop_acc;
    assign frm_set = capture && rx_error;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (state_q == StFlush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)    wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop_acc)      count_d = count_q + CW'(1);
            else if (!push && pop_acc) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    always_comb begin
        ovr_d = (ovr_q && !err_clr) || ovr_set;
        frm_d = (frm_q && !err_clr) || frm_set;
    end

    always_comb begin
        tmo_clr = rx_done || pop_acc || rx_busy ||
                  (state_q != StActive) || (state_d != StActive);
        tmo_cnt_d = tmo_cnt_q;
        if (tmo_clr) begin
            tmo_cnt_d = '0;
        end else if (count_q != '0 && cfg_timeout != '0 && tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
        end
        flag_d = flag_q;
        if (cfg_timeout != '0 && tmo_cnt_q == cfg_timeout) flag_d = 1'b1;
        if (state_q == StFlush || pop_acc || count_d == '0) flag_d = 1'b0;
    end

    assign rd_valid     = (count_q != '0);
    assign rd_data      = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count   = count_q;
    assign ovr_err      = ovr_q;
    assign frm_err      = frm_q;
    assign timeout_flag = flag_q;
    assign irq          = (count_q >= CW'(FIFO_DEPTH / 2)) || flag_q || ovr_q || frm_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a byte scoreboard predicts FIFO contents, and
// control/flag outputs are compared against expected constants per scenario.
module tb_uart_rx_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cfg_enable = 1'b0, cfg_flush = 1'b0, err_clr = 1'b0, rd_pop = 1'b0;
    logic [TW-1:0] cfg_timeout = '0;
    logic          rx_done = 1'b0, rx_busy = 1'b0, rx_error = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_en, rx_rst, rd_valid, ovr_err, frm_err, timeout_flag, irq;
    logic [DW-1:0] rd_data;
    logic [$clog2(DEPTH):0] fifo_count;

    logic [DW-1:0] sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_ctrl #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_W(TW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .cfg_enable(cfg_enable), .cfg_flush(cfg_flush),
        .cfg_timeout(cfg_timeout), .err_clr(err_clr), .rd_pop(rd_pop), .rx_done(rx_done),
        .rx_busy(rx_busy), .rx_error(rx_error), .rx_data(rx_data), .rx_en(rx_en),
        .rx_rst(rx_rst), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .ovr_err(ovr_err), .frm_err(frm_err), .timeout_flag(timeout_flag), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic err, input logic accept);
        rx_data  = d;
        rx_error = err;
        rx_done  = 1'b1;
        if (accept) sb.push_back(d);
        tick();
        rx_done  = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [DW-1:0] exp;
        exp = (sb.size() != 0) ? sb.pop_front() : '0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check(tag, 32'(rd_data), 32'(exp));
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        check({tag, "_cnt"}, 32'(fifo_count), 32'(sb.size()));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_en", 32'(rx_en), 32'd0);
        check("rst_rst", 32'(rx_rst), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_cnt", 32'(fifo_count), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_flags", {29'd0, ovr_err, frm_err, timeout_flag}, 32'd0);

        // Enable sequence: one FLUSH cycle, then ACTIVE
        PRESETn    = 1'b1;
        cfg_enable = 1'b1;
        tick();
        check("en_flush_rst", 32'(rx_rst), 32'd1);
        check("en_flush_en", 32'(rx_en), 32'd0);
        tick();
        check("en_act_rst", 32'(rx_rst), 32'd0);
        check("en_act_en", 32'(rx_en), 32'd1);
        send(8'hA5, 1'b0, 1'b1);
        check("a5_cnt", 32'(fifo_count), 32'd1);
        pop_chk("a5_pop");
        check("empty_data", 32'(rd_data), 32'd0);

        // Fill and overrun
        for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0, 1'b1);
        check("full_cnt", 32'(fifo_count), 32'd4);
        check("full_irq", 32'(irq), 32'd1);
        check("full_ovr0", 32'(ovr_err), 32'd0);
        send(8'h05, 1'b0, 1'b0);
        check("ovr_set", 32'(ovr_err), 32'd1);
        check("ovr_cnt", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) pop_chk("fill_pop");
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        check("empty_pop_cnt", 32'(fifo_count), 32'd0);
        check("empty_pop_valid", 32'(rd_valid), 32'd0);
        check("ovr_sticky_irq", 32'(irq), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_clr", 32'(ovr_err), 32'd0);

        // Push into empty with a pop in the same cycle: pop ignored
        rx_data = 8'h66; rx_done = 1'b1; rd_pop = 1'b1;
        sb.push_back(8'h66);
        tick();
        rx_done = 1'b0; rd_pop = 1'b0;
        check("pe_cnt", 32'(fifo_count), 32'd1);
        pop_chk("pe_pop");

        // Full-FIFO concurrent push and pop
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b1);
        send(8'h44, 1'b0, 1'b1);
        check("cc_head", 32'(rd_data), 32'(sb[0]));
        void'(sb.pop_front());
        sb.push_back(8'h55);
        rx_data = 8'h55; rx_done = 1'b1; rd_pop = 1'b1;
        tick();
        rx_done = 1'b0; rd_pop = 1'b0;
        check("cc_cnt", 32'(fifo_count), 32'd4);
        check("cc_ovr", 32'(ovr_err), 32'd0);
        for (int i = 0; i < 4; i++) pop_chk("cc_pop");

        // Framing error coincident with err_clr: set wins
        err_clr = 1'b1;
        send(8'hEE, 1'b1, 1'b0);
        err_clr = 1'b0;
        check("frm_win", 32'(frm_err), 32'd1);
        check("frm_nopush", 32'(fifo_count), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("frm_clr", 32'(frm_err), 32'd0);

        // Graceful disable
        rx_busy    = 1'b1;
        cfg_enable = 1'b0;
        tick();
        check("drain_en", 32'(rx_en), 32'd0);
        check("drain_rst", 32'(rx_rst), 32'd0);
        cfg_enable = 1'b1;
        tick();
        check("drain_reen_rst", 32'(rx_rst), 32'd0);
        check("drain_reen_en", 32'(rx_en), 32'd0);
        cfg_enable = 1'b0;
        rx_busy    = 1'b0;
        send(8'h3C, 1'b0, 1'b1);
        check("drain_cap_cnt", 32'(fifo_count), 32'd1);
        tick();
        send(8'h99, 1'b0, 1'b0);
        check("off_ignore_cnt", 32'(fifo_count), 32'd1);
        pop_chk("drain_pop");
        cfg_enable = 1'b1;
        tick();
        check("reen_flush", 32'(rx_rst), 32'd1);
        tick();
        check("reen_active", 32'(rx_en), 32'd1);

        // Idle timeout
        cfg_timeout = TW'(10);
        send(8'h7E, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check("tmo_early", 32'(timeout_flag), 32'd0);
        check("tmo_early_irq", 32'(irq), 32'd0);
        tick();
        check("tmo_set", 32'(timeout_flag), 32'd1);
        check("tmo_irq", 32'(irq), 32'd1);
        pop_chk("tmo_pop");
        check("tmo_clr", 32'(timeout_flag), 32'd0);
        cfg_timeout = '0;
        send(8'h81, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) tick();
        check("tmo_dis", 32'(timeout_flag), 32'd0);
        pop_chk("tmo_dis_pop");

        // Flush keeps error flags, empties FIFO
        send(8'h00, 1'b1, 1'b0);
        send(8'hA1, 1'b0, 1'b1);
        send(8'hA2, 1'b0, 1'b1);
        send(8'hA3, 1'b0, 1'b1);
        check("fl_cnt3", 32'(fifo_count), 32'd3);
        cfg_flush = 1'b1;
        tick();
        cfg_flush = 1'b0;
        check("fl_rst", 32'(rx_rst), 32'd1);
        check("fl_en", 32'(rx_en), 32'd0);
        tick();
        sb.delete();
        check("fl_active", 32'(rx_en), 32'd1);
        check("fl_rst_end", 32'(rx_rst), 32'd0);
        check("fl_cnt0", 32'(fifo_count), 32'd0);
        check("fl_frm_kept", 32'(frm_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("fl_irq0", 32'(irq), 32'd0);

        // Reset asserted mid-DRAIN with a pending capture
        send(8'h77, 1'b0, 1'b1);
        rx_busy    = 1'b1;
        cfg_enable = 1'b0;
        tick();
        check("rd_drain_en", 32'(rx_en), 32'd0);
        send(8'h00, 1'b1, 1'b0);
        check("rd_frm", 32'(frm_err), 32'd1);
        PRESETn = 1'b0;
        rx_data = 8'h88;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_busy = 1'b0;
        sb.delete();
        check("rd_en", 32'(rx_en), 32'd0);
        check("rd_rst", 32'(rx_rst), 32'd0);
        check("rd_valid", 32'(rd_valid), 32'd0);
        check("rd_data", 32'(rd_data), 32'd0);
        check("rd_cnt", 32'(fifo_count), 32'd0);
        check("rd_flags", {29'd0, ovr_err, frm_err, timeout_flag}, 32'd0);
        check("rd_irq", 32'(irq), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
